// File: rtl/uart_frame_sequencer.sv
// UART front-end for the CNN pipeline: frames pixel bytes into the ifmap,
// starts inference once per complete frame, and returns the ASCII result.
// Optional feature macro: FRAME_CHECKSUM_EN (trailing 8-bit modular-sum byte per frame).
module uart_frame_sequencer #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FRAC_BITS      = 7,
  parameter int unsigned IMG_SIZE       = 28,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned ADDR_W        = $clog2(IMG_SIZE * IMG_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  output logic                  pix_we,
  output logic [ADDR_W-1:0]     pix_addr,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  frame_start,
  input  logic                  result_valid,
  input  logic [3:0]            result_digit,
  output logic                  tx_dv,
  output logic [7:0]            tx_byte,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic [7:0]            timeout_cnt,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned NPIX  = IMG_SIZE * IMG_SIZE;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  // Abort fires on the quiet cycle that brings the timer to TIMEOUT_CYCLES-1.
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ERR  = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef FRAME_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  count;
  logic [TMR_W-1:0]   timer;
  logic [7:0]         pend_byte;
  logic               seen_busy;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]         sum;
`endif

  // Frame/result sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      timer       <= '0;
      pend_byte   <= '0;
      seen_busy   <= 1'b0;
      pix_we      <= 1'b0;
      pix_addr    <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
      tx_dv       <= 1'b0;
      tx_byte     <= '0;
      busy        <= 1'b0;
      timeout_cnt <= '0;
      drop_cnt    <= '0;
`ifdef FRAME_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      pix_we      <= 1'b0;
      frame_start <= 1'b0;
      tx_dv       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rx_dv && (rx_byte == SYNC_BYTE)) begin
            state <= S_LOAD;
            busy  <= 1'b1;
            count <= '0;
            timer <= '0;
`ifdef FRAME_CHECKSUM_EN
            sum   <= '0;
`endif
          end
        end

        S_LOAD: begin
          if (rx_dv) begin
            pix_we   <= 1'b1;
            pix_addr <= count;
            pix_data <= DATA_WIDTH'(rx_byte) << FRAC_BITS;
            count    <= count + ADDR_W'(1);
            timer    <= '0;
`ifdef FRAME_CHECKSUM_EN
            sum      <= sum + rx_byte;
            if (count == LAST_PIX) state <= S_CHECK;
`else
            if (count == LAST_PIX) begin
              frame_start <= 1'b1;
              state       <= S_RUN;
            end
`endif
          end else if (timer == TMR_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

`ifdef FRAME_CHECKSUM_EN
        S_CHECK: begin
          if (rx_dv) begin
            if (rx_byte == sum) begin
              frame_start <= 1'b1;
              state       <= S_RUN;
            end else begin
              pend_byte <= ASCII_ERR;
              state     <= S_SEND;
            end
          end else if (timer == TMR_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
`endif

        S_RUN: begin
          // Idle transmitter: skip SEND so tx_dv follows result_valid by one cycle.
          if (result_valid) begin
            if (!tx_busy) begin
              tx_dv     <= 1'b1;
              tx_byte   <= ASCII_ZERO + {4'h0, result_digit};
              seen_busy <= 1'b0;
              state     <= S_WAIT_TX;
            end else begin
              pend_byte <= ASCII_ZERO + {4'h0, result_digit};
              state     <= S_SEND;
            end
          end
        end

        S_SEND: begin
          if (!tx_busy) begin
            tx_dv     <= 1'b1;
            tx_byte   <= pend_byte;
            seen_busy <= 1'b0;
            state     <= S_WAIT_TX;
          end
        end

        S_WAIT_TX: begin
          if (seen_busy && !tx_busy) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tx_busy) begin
            seen_busy <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Bytes arriving while a frame is in flight are counted, not consumed.
      if (rx_dv && ((state == S_RUN) || (state == S_SEND) || (state == S_WAIT_TX))) begin
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
